// File: rtl/jtag_shift_bridge.sv
`default_nettype none
// ============================================================================
// Module   : jtag_shift_bridge
// Purpose  : Host byte stream <-> TAP FSM bit stream bridge. TDI bytes are
//            serialised with prefetch; captured TDO bits are packed into bytes.
// Config   : JTAG_BRIDGE_MSB_FIRST_EN selects MSB-first order on both paths.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_shift_bridge #(
    parameter  int DATA_W = 8,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jtag_rd_en,
    input  logic              jtag_wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic [CNT_W-2:0]  din_nbits,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              shift_in,
    input  logic              shift_in_rd,
    output logic              shift_in_last,
    input  logic              shift_out,
    input  logic              shift_out_wr,
    output logic              shift_out_last,
    input  logic              out_flush,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-2:0]  dout_nbits,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    logic [DATA_W-1:0] pre_q, pre_d;
    logic [CNT_W-2:0]  pre_n_q, pre_n_d;
    logic              pre_v_q, pre_v_d;
    logic [DATA_W-1:0] isr_q, isr_d;
    logic [CNT_W-1:0]  icnt_q, icnt_d;
    logic              shift_in_q, shift_in_d;
    logic              shift_in_last_q, shift_in_last_d;
    logic [DATA_W-1:0] osr_q, osr_d;
    logic [CNT_W-1:0]  ocnt_q, ocnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CNT_W-2:0]  dout_nbits_q, dout_nbits_d;
    logic              dout_valid_q, dout_valid_d;
    logic              ovf_q, ovf_d;

    logic              w_consume;
    logic              w_capture;
    logic              w_accept;
    logic              w_hold_free;
    logic [CNT_W-1:0]  w_load_cnt;
    logic [CNT_W-1:0]  w_opos_full;
    logic [CNT_W-2:0]  w_opos;

    assign w_consume = shift_in_rd & jtag_wr_en;
    assign w_capture = shift_out_wr & jtag_rd_en;
    assign w_accept  = din_valid & ~pre_v_q;

    // Input path: the consume is applied first, so an isr that just drained
    // refills from pre in the same edge without a bubble.
    always_comb begin
        pre_d      = pre_q;
        pre_n_d    = pre_n_q;
        pre_v_d    = pre_v_q;
        isr_d      = isr_q;
        icnt_d     = icnt_q;
        w_load_cnt = (pre_n_q == '0) ? c_FULL_CNT : {1'b0, pre_n_q};

        if (w_consume && (icnt_q != '0)) begin
`ifdef JTAG_BRIDGE_MSB_FIRST_EN
            isr_d = isr_q << 1;
`else
            isr_d = isr_q >> 1;
`endif
            icnt_d = icnt_q - c_ONE;
        end

        if (pre_v_q && (icnt_d == '0)) begin
`ifdef JTAG_BRIDGE_MSB_FIRST_EN
            isr_d = pre_q << (c_FULL_CNT - w_load_cnt);
`else
            isr_d = pre_q;
`endif
            icnt_d  = w_load_cnt;
            pre_v_d = 1'b0;
        end

        if (w_accept) begin
            pre_d   = din;
            pre_n_d = din_nbits;
            pre_v_d = 1'b1;
        end

`ifdef JTAG_BRIDGE_MSB_FIRST_EN
        shift_in_d = (icnt_d != '0) ? isr_d[DATA_W-1] : 1'b0;
`else
        shift_in_d = (icnt_d != '0) ? isr_d[0] : 1'b0;
`endif
        shift_in_last_d = (icnt_d <= c_ONE) && !pre_v_d;
    end

    // Output path: capture is resolved before flush, so a flush coinciding
    // with a completing capture sees an empty packer.
    always_comb begin
        osr_d        = osr_q;
        ocnt_d       = ocnt_q;
        dout_d       = dout_q;
        dout_nbits_d = dout_nbits_q;
        dout_valid_d = dout_valid_q;
        ovf_d        = ovf_q;
        w_hold_free  = ~dout_valid_q | dout_ready;
`ifdef JTAG_BRIDGE_MSB_FIRST_EN
        w_opos_full  = c_FULL_CNT - c_ONE - ocnt_q;
`else
        w_opos_full  = ocnt_q;
`endif
        w_opos       = w_opos_full[CNT_W-2:0];

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (w_capture) begin
            osr_d[w_opos] = shift_out;
            if (ocnt_q == (c_FULL_CNT - c_ONE)) begin
                if (w_hold_free) begin
                    dout_d       = osr_d;
                    dout_nbits_d = '0;
                    dout_valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                osr_d  = '0;
                ocnt_d = '0;
            end else begin
                ocnt_d = ocnt_q + c_ONE;
            end
        end

        if (out_flush && (ocnt_d != '0) && w_hold_free) begin
`ifdef JTAG_BRIDGE_MSB_FIRST_EN
            dout_d = osr_d >> (c_FULL_CNT - ocnt_d);
`else
            dout_d = osr_d;
`endif
            dout_nbits_d = ocnt_d[CNT_W-2:0];
            dout_valid_d = 1'b1;
            osr_d        = '0;
            ocnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q           <= '0;
            pre_n_q         <= '0;
            pre_v_q         <= 1'b0;
            isr_q           <= '0;
            icnt_q          <= '0;
            shift_in_q      <= 1'b0;
            shift_in_last_q <= 1'b1;
            osr_q           <= '0;
            ocnt_q          <= '0;
            dout_q          <= '0;
            dout_nbits_q    <= '0;
            dout_valid_q    <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            pre_q           <= pre_d;
            pre_n_q         <= pre_n_d;
            pre_v_q         <= pre_v_d;
            isr_q           <= isr_d;
            icnt_q          <= icnt_d;
            shift_in_q      <= shift_in_d;
            shift_in_last_q <= shift_in_last_d;
            osr_q           <= osr_d;
            ocnt_q          <= ocnt_d;
            dout_q          <= dout_d;
            dout_nbits_q    <= dout_nbits_d;
            dout_valid_q    <= dout_valid_d;
            ovf_q           <= ovf_d;
        end
    end

    assign din_ready      = ~pre_v_q;
    assign shift_in       = shift_in_q;
    assign shift_in_last  = shift_in_last_q;
    assign shift_out_last = (ocnt_q == (c_FULL_CNT - c_ONE)) && dout_valid_q && ~dout_ready;
    assign dout           = dout_q;
    assign dout_nbits     = dout_nbits_q;
    assign dout_valid     = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_shift_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_shift_bridge
// Purpose  : Directed and random stimulus against a bit-queue model of the bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_shift_bridge;

`ifdef JTAG_BRIDGE_MSB_FIRST_EN
    localparam bit MSB_MODE = 1'b1;
`else
    localparam bit MSB_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       jtag_rd_en, jtag_wr_en;
    logic [7:0] din;
    logic [2:0] din_nbits;
    logic       din_valid, din_ready;
    logic       shift_in, shift_in_rd, shift_in_last;
    logic       shift_out, shift_out_wr, shift_out_last;
    logic       out_flush;
    logic [7:0] dout;
    logic [2:0] dout_nbits;
    logic       dout_valid, dout_ready;

    always #5 clk = ~clk;

    jtag_shift_bridge #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .jtag_rd_en(jtag_rd_en), .jtag_wr_en(jtag_wr_en),
        .din(din), .din_nbits(din_nbits), .din_valid(din_valid), .din_ready(din_ready),
        .shift_in(shift_in), .shift_in_rd(shift_in_rd), .shift_in_last(shift_in_last),
        .shift_out(shift_out), .shift_out_wr(shift_out_wr), .shift_out_last(shift_out_last),
        .out_flush(out_flush), .dout(dout), .dout_nbits(dout_nbits),
        .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: bits waiting to be shifted, bits captured so far, holding reg.
    logic       m_cur[$];
    logic       m_pre[$];
    bit         m_pre_v;
    logic       m_obits[$];
    logic [7:0] m_dout;
    logic [2:0] m_dnb;
    bit         m_dv;
    bit         m_ovf;

    function automatic int bidx(input int i, input int n);
        return MSB_MODE ? (n - 1 - i) : i;
    endfunction

    function automatic logic [7:0] pack_obits();
        logic [7:0] v;
        int n;
        v = '0;
        n = m_obits.size();
        for (int i = 0; i < n; i++) v[bidx(i, n)] = m_obits[i];
        return v;
    endfunction

    task automatic model_reset();
        m_cur.delete(); m_pre.delete(); m_obits.delete();
        m_pre_v = 0; m_dout = '0; m_dnb = '0; m_dv = 0; m_ovf = 0;
    endtask

    task automatic model_step(input logic dv, input logic [7:0] d, input logic [2:0] dn,
                              input logic consume, input logic capture, input logic so,
                              input logic fl, input logic dr);
        bit pre_v_old;
        bit free;
        int n;
        pre_v_old = m_pre_v;
        if (consume && m_cur.size() > 0) void'(m_cur.pop_front());
        if (m_cur.size() == 0 && m_pre_v) begin
            m_cur = m_pre;
            m_pre_v = 0;
        end
        if (dv && !pre_v_old) begin
            n = (dn == 0) ? 8 : int'(dn);
            m_pre.delete();
            for (int i = 0; i < n; i++) m_pre.push_back(d[bidx(i, n)]);
            m_pre_v = 1;
        end
        free = !m_dv || dr;
        if (m_dv && dr) m_dv = 0;
        if (capture) begin
            m_obits.push_back(so);
            if (m_obits.size() == 8) begin
                if (free) begin
                    m_dout = pack_obits(); m_dnb = 0; m_dv = 1;
                end else begin
                    m_ovf = 1;
                end
                m_obits.delete();
            end
        end
        if (fl && m_obits.size() != 0 && free) begin
            m_dout = pack_obits();
            m_dnb  = 3'(m_obits.size());
            m_dv   = 1;
            m_obits.delete();
        end
    endtask

    task automatic check_outputs();
        check("din_ready", 32'(din_ready), 32'(!m_pre_v));
        check("shift_in", 32'(shift_in), 32'((m_cur.size() > 0) ? m_cur[0] : 1'b0));
        check("shift_in_last", 32'(shift_in_last), 32'(m_cur.size() <= 1 && !m_pre_v));
        check("dout_valid", 32'(dout_valid), 32'(m_dv));
        check("dout", 32'(dout), 32'(m_dout));
        check("dout_nbits", 32'(dout_nbits), 32'(m_dnb));
        check("ovf", 32'(dut.ovf_q), 32'(m_ovf));
    endtask

    task automatic cycle(input logic dv, input logic [7:0] d, input logic [2:0] dn,
                         input logic rd, input logic wen, input logic ren, input logic wr,
                         input logic so, input logic fl, input logic dr);
        din_valid = dv; din = d; din_nbits = dn; shift_in_rd = rd; jtag_wr_en = wen;
        jtag_rd_en = ren; shift_out_wr = wr; shift_out = so; out_flush = fl; dout_ready = dr;
        #1;
        check("shift_out_last", 32'(shift_out_last), 32'(m_obits.size() == 7 && m_dv && !dr));
        model_step(dv, d, dn, rd && wen, wr && ren, so, fl, dr);
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic push_byte(input logic [7:0] d, input logic [2:0] dn);
        cycle(1'b1, d, dn, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic consume();
        cycle(1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic capture(input logic b, input logic dr);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, b, 1'b0, dr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 0; din = '0; din_nbits = '0; shift_in_rd = 0; jtag_wr_en = 0;
        jtag_rd_en = 0; shift_out_wr = 0; shift_out = 0; out_flush = 0; dout_ready = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_shift_in", 32'(shift_in), 32'd0);
        check("rst_shift_in_last", 32'(shift_in_last), 32'd1);
        check("rst_shift_out_last", 32'(shift_out_last), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_nbits", 32'(dout_nbits), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_ovf", 32'(dut.ovf_q), 32'd0);
    endtask

    initial begin
        logic [7:0]  pat;
        logic [15:0] got, lastv;
        logic [7:0]  bv;
        logic [4:0]  fb;
        bit          seen_low, started, rdy;
        int          k, nb;

        // A5, LSB-first stream with last only on the final bit
        do_reset();
        push_byte(8'hA5, 3'd0);
        check("a5_pre_last", 32'(shift_in_last), 32'd0);
        idle();
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check("a5_bit", 32'(shift_in), 32'(pat[bidx(i, 8)]));
            check("a5_last", 32'(shift_in_last), 32'(i == 7));
            consume();
        end
        check("a5_empty_last", 32'(shift_in_last), 32'd1);
        check("a5_empty_bit", 32'(shift_in), 32'd0);

        // FF then 00 back to back, consuming every cycle
        do_reset();
        k = 0; nb = 0; got = '0; lastv = '0; seen_low = 0; started = 0;
        for (int c = 0; c < 24; c++) begin
            bv = (k == 0) ? 8'hFF : 8'h00;
            if (!din_ready) seen_low = 1;
            if (started || shift_in) begin
                started = 1;
                if (nb < 16) begin
                    got[nb] = shift_in;
                    lastv[nb] = shift_in_last;
                end
                nb++;
            end
            rdy = din_ready;
            cycle(k < 2, bv, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (rdy && k < 2) k++;
        end
        check("ff00_bits", 32'(got), 32'h00FF);
        check("ff00_last", 32'(lastv), 32'h8000);
        check("ff00_ready_drop", 32'(seen_low), 32'd1);

        // Short byte: 05 with 3 valid bits
        do_reset();
        push_byte(8'h05, 3'd3);
        idle();
        pat = 8'h05;
        for (int i = 0; i < 3; i++) begin
            check("short_bit", 32'(shift_in), 32'(pat[bidx(i, 3)]));
            consume();
        end
        check("short_last", 32'(shift_in_last), 32'd1);
        check("short_zero", 32'(shift_in), 32'd0);

        // Full byte capture with dout_ready high
        do_reset();
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) capture(pat[bidx(i, 8)], 1'b1);
        check("cap_dout", 32'(dout), 32'h3C);
        check("cap_nbits", 32'(dout_nbits), 32'd0);
        check("cap_valid", 32'(dout_valid), 32'd1);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("cap_valid_drop", 32'(dout_valid), 32'd0);

        // Backpressure: 15 captures raise shift_out_last, the 16th overflows
        do_reset();
        for (int i = 0; i < 15; i++) capture(1'(i), 1'b0);
        check("bp_last", 32'(shift_out_last), 32'd1);
        capture(1'b1, 1'b0);
        check("bp_ovf", 32'(dut.ovf_q), 32'd1);

        // Partial byte flush
        do_reset();
        fb = 5'b01101;
        for (int i = 0; i < 5; i++) capture(fb[i], 1'b0);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("flush_nbits", 32'(dout_nbits), 32'd5);
        check("flush_dout", 32'(dout), MSB_MODE ? 32'h16 : 32'h0D);
        check("flush_valid", 32'(dout_valid), 32'd1);

        // Reset mid-shift, then a fresh byte starts from its first bit
        do_reset();
        push_byte(8'hA5, 3'd0);
        idle();
        for (int i = 0; i < 3; i++) consume();
        do_reset();
        push_byte(8'h01, 3'd0);
        idle();
        pat = 8'h01;
        check("rst_fresh_bit0", 32'(shift_in), 32'(pat[bidx(0, 8)]));
        consume();
        check("rst_fresh_bit1", 32'(shift_in), 32'(pat[bidx(1, 8)]));

        // Random traffic against the model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                cycle(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                      1'($urandom_range(0, 2) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
